// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned PTR_W = $clog2(DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port,
// contents cleared by the asynchronous reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned IDX_W      = $clog2(DEFAULT_DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_nreset,
    input  logic                  i_write_en,
    input  logic [IDX_W-1:0]      i_write_index,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic [IDX_W-1:0]      i_read_index,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next-state: update only the addressed entry on a write.
    always_comb begin
        mem_d = mem_q;
        if (i_write_en) begin
            mem_d[i_write_index] = i_write_data;
        end
    end

    // Storage flops with asynchronous clear.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        o_read_data = mem_q[i_read_index];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and first-word-fall-through output.
// Full/empty come from wrap-bit pointers so all handshake outputs depend on state only.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  i_clock,
    input  logic                  i_nreset,
    input  logic                  i_write_valid,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_write_ready,
    output logic                  o_read_valid,
    output logic [DATA_WIDTH-1:0] o_read_data,
    input  logic                  i_read_ready
);

    localparam int unsigned PTR_WIDTH = ptr_width(DEPTH);
    localparam int unsigned IDX_W     = PTR_WIDTH - 1;

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                 full;
    logic                 empty;
    logic                 write_fire;
    logic                 read_fire;

    // Occupancy flags and transfer qualifiers from registered pointers.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                     (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        write_fire = i_write_valid && !full;
        read_fire  = i_read_ready && !empty;
    end

    // Pointer advance; the wrap bit rolls naturally with the extra pointer bit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (write_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (read_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
    end

    // Pointer registers with asynchronous reset.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .i_clock       (i_clock),
        .i_nreset      (i_nreset),
        .i_write_en    (write_fire),
        .i_write_index (wr_ptr_q[IDX_W-1:0]),
        .i_write_data  (i_write_data),
        .i_read_index  (rd_ptr_q[IDX_W-1:0]),
        .o_read_data   (o_read_data)
    );

    // Handshake outputs; no path from i_read_ready to o_write_ready.
    always_comb begin
        o_write_ready = !full;
        o_read_valid  = !empty;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo with a queue-based scoreboard.
module tb_sync_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          i_clock = 1'b0;
    logic          i_nreset;
    logic          i_write_valid;
    logic [DW-1:0] i_write_data;
    logic          o_write_ready;
    logic          o_read_valid;
    logic [DW-1:0] o_read_data;
    logic          i_read_ready;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clock       (i_clock),
        .i_nreset      (i_nreset),
        .i_write_valid (i_write_valid),
        .i_write_data  (i_write_data),
        .o_write_ready (o_write_ready),
        .o_read_valid  (o_read_valid),
        .o_read_data   (o_read_data),
        .i_read_ready  (i_read_ready)
    );

    always #5 i_clock = ~i_clock;

    int            checks = 0;
    int            errors = 0;
    int            cnt    = 0;  // model occupancy
    logic [DW-1:0] exp_q[$];    // words expected at the read side, oldest first
    bit            mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr);
        bit w_acc;
        bit r_acc;
        i_write_valid = wv;
        i_write_data  = wd;
        i_read_ready  = rr;
        @(posedge i_clock);
        w_acc = wv && (cnt < int'(DEPTH));
        r_acc = rr && (cnt > 0);
        if (w_acc) exp_q.push_back(wd);
        cnt = cnt + int'(w_acc) - int'(r_acc);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string name);
        #1 i_nreset = 1'b0;
        exp_q.delete();
        cnt = 0;
        #1;
        check({name, "_valid"}, int'(o_read_valid), 0);
        check({name, "_ready"}, int'(o_write_ready), 1);
        check({name, "_data"}, int'(o_read_data), 0);
        i_nreset = 1'b1;
    endtask

    // Monitor: flags vs model occupancy, head vs scoreboard, pop on read transfer.
    always @(negedge i_clock) begin
        if (mon_en && i_nreset) begin
            check("read_valid", int'(o_read_valid), int'(cnt > 0));
            check("write_ready", int'(o_write_ready), int'(cnt < int'(DEPTH)));
            if (o_read_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_data: got %0d, expected no word at %0t",
                             o_read_data, $time);
                end else begin
                    check("head_data", int'(o_read_data), int'(exp_q[0]));
                    if (i_read_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_nreset      = 1'b0;
        i_write_valid = 1'b0;
        i_write_data  = '0;
        i_read_ready  = 1'b0;
        #3;
        check("reset_valid", int'(o_read_valid), 0);
        check("reset_ready", int'(o_write_ready), 1);
        check("reset_data", int'(o_read_data), 0);
        #4 i_nreset = 1'b1;
        mon_en = 1'b1;

        // Single write, then idle so the word is observed.
        step(1'b1, 8'd12, 1'b0);
        step(1'b0, 8'd0, 1'b0);

        // Fill with five writes; the fifth is refused.
        for (int i = 0; i < 4; i++) step(1'b1, 8'd12, 1'b0);
        check("fill_ready", int'(o_write_ready), 0);
        check("fill_head", int'(o_read_data), 12);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1);

        // Drain order.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
        check("drain_valid", int'(o_read_valid), 0);

        // Streaming at occupancy 2 across several pointer wraps.
        step(1'b1, 8'd10, 1'b0);
        step(1'b1, 8'd11, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(12 + i), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b1);

        // Read and write while full: only the read happens.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(40 + i), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        check("full_rw_ready", int'(o_write_ready), 1);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);

        // Reset with three words stored.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(70 + i), 1'b0);
        reset_pulse("midreset");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), DW'($urandom), 1'($urandom_range(0, 99) < 50));
            if (i == 200) reset_pulse("randreset");
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Synchronous first-in/first-out buffer, 8 bits wide and 4 entries deep, with valid/ready handshakes on both its write (producer) side and its read (consumer) side. It decouples a producer from a consumer in a single clock domain and absorbs up to 4 words of backpressure. The head entry is presented in first-word-fall-through fashion, so `o_read_data` is valid whenever `o_read_valid` is high.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, word width in bits.
- `DEPTH`, default 4, number of entries; must be a power of two and at least 2.

Ports:
- `i_clock`, input, 1 bit. Single clock; all state updates on the rising edge.
- `i_nreset`, input, 1 bit. Reset is asynchronous and active-low.
- `i_write_valid`, input, 1 bit. Producer offers `i_write_data`.
- `i_write_data`, input, `DATA_WIDTH` bits. Word to enqueue.
- `o_write_ready`, output, 1 bit. FIFO can accept a word (not full).
- `o_read_valid`, output, 1 bit. FIFO holds at least one word (not empty).
- `o_read_data`, output, `DATA_WIDTH` bits. Head-of-queue word.
- `i_read_ready`, input, 1 bit. Consumer accepts the head word.

## Operation
- Write transfer: occurs when `i_write_valid && o_write_ready` at a rising clock edge. The word is stored at the write pointer, and the write pointer advances by 1 modulo `DEPTH`.
- Read transfer: occurs when `o_read_valid && i_read_ready` at a rising clock edge. The read pointer advances by 1 modulo `DEPTH`.
- Occupancy tracking:
  - Read and write pointers are each `log2(DEPTH)+1` bits, using the extra wrap bit.
  - Empty: the pointers are equal.
  - Full: the index bits are equal and the wrap bits differ.
- Output derivation:
  - `o_write_ready = !full`, registered-state derived, with no combinational path from `i_read_ready`.
  - `o_read_valid = !empty`.
  - `o_read_data` = memory entry at the read-pointer index, combinational from registered state.
- Simultaneous read and write:
  - When neither full nor empty: both happen and occupancy is unchanged.
  - When full: only the read happens. The write is refused because `o_write_ready` is 0. Occupancy becomes `DEPTH`-1.
  - When empty: only the write happens; there is no bypass. Data appears on the next cycle.
- Write attempted while full: ignored, with no state change. Read requested while empty: ignored.
- Data ordering: strict FIFO order, with no data corruption across pointer wrap-around.
- Empty behaviour: when empty, `o_read_data` shows the stale entry at the read pointer, which is 0 if never written since reset. Consumers must qualify it with `o_read_valid`.

## Timing
- Reset (`i_nreset`=0, takes effect immediately, independent of the clock):
  - Both pointers go to 0.
  - All memory entries go to 0.
  - Outputs: `o_read_valid`=0, `o_write_ready`=1, `o_read_data`=0.
- Reset release: the first transfer can occur on the first rising edge with `i_nreset`=1.
- Write-to-read latency: 1 cycle. A word accepted at edge N makes `o_read_valid`=1 and presents the word on `o_read_data` after edge N.
- Full-flag timing: after the `DEPTH`-th unread write, `o_write_ready` drops to 0 right after that edge. It returns to 1 right after the edge of the next read transfer.
- Reset mid-operation: all contents are discarded and outputs return to their reset values asynchronously.

## Structure
- Shared package `fifo_pkg`:
  - Default `DATA_WIDTH`/`DEPTH` constants.
  - Helper constant `PTR_W = $clog2(DEPTH)+1`.
- One natural sub-module, `fifo_mem`:
  - `DEPTH` x `DATA_WIDTH` register array.
  - One write port (enable, index, data) and one asynchronous read port (index → data).
  - Asynchronous clear on `i_nreset`.
- Top-level `sync_fifo` holds the pointers, full/empty logic and handshake outputs.

## Test plan
- **Reset:** hold `i_nreset`=0 for 1 cycle, then release → `o_read_valid`=0, `o_write_ready`=1, `o_read_data`=8'd0.
- **Single write:** `i_write_data`=12, `i_write_valid`=1 for one cycle, `i_read_ready`=0 → next cycle `o_read_valid`=1, `o_read_data`=12, `o_write_ready`=1.
- **Fill:** hold `i_write_valid`=1 with data 12 for 5 cycles, `i_read_ready`=0 → `o_read_valid`=1 from cycle 1. `o_write_ready`=0 after the 4th accepted write. The 5th word is not stored, and the head stays 12.
- **Drain order:** write 1, 2, 3, 4, then `i_read_ready`=1 → `o_read_data` shows 1, 2, 3, 4 on consecutive cycles. `o_read_valid`=0 after the 4th read.
- **Simultaneous read/write:**
  - At occupancy 2: streaming writes 10, 11, … with `i_read_ready`=1 → occupancy stays 2 and order is preserved across pointer wrap.
  - At full: read + write in the same cycle → only the read occurs and `o_write_ready` returns to 1.
- **Reset mid-operation:** with 3 words stored, pulse `i_nreset` low between clock edges → `o_read_valid`=0 and `o_write_ready`=1 immediately, without waiting for a clock edge.
